fetch_pc_unit: RTL and testbench

Program-counter and fetch stage of the single-cycle MIPS core. Holds the PC, addresses instruction ROM, splits the fetched word into the `operator`/`special` fields consumed by the controller, and computes the next PC from the controller's `pcWrite`/`jump`/`bltz` outputs and ALU flags. Owns the run/pause/halt state machine driven by `syscall`, and optional execution statistics.

---
 rtl/fetch_pc_unit_if.sv | 40 ++++
 rtl/fetch_pc_unit.sv | 131 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus between fetch_pc_unit and the rest of the core (controller, ALU, regfile, ROM, board).
// The master modport is the fetch unit; the slave modport is its surrounding logic.
interface fetch_pc_unit_if #(
  parameter int ROM_AW = 10
);
  logic              go;
  logic [31:0]       instruction;
  logic [1:0]        pcWrite;
  logic              jump;
  logic              bltz;
  logic              syscall;
  logic              aluEqual;
  logic              aluLess;
  logic [31:0]       rsValue;
  logic [31:0]       v0Value;

  logic [ROM_AW-1:0] instrAddr;
  logic [5:0]        operator;
  logic [5:0]        special;
  logic [31:0]       pc;
  logic [31:0]       pcPlus4;
  logic              instrValid;
  logic              paused;
  logic              halted;
  logic [31:0]       cycleCount;
  logic [31:0]       jumpCount;
  logic [31:0]       branchCount;

  modport master (
    input  go, instruction, pcWrite, jump, bltz, syscall, aluEqual, aluLess, rsValue, v0Value,
    output instrAddr, operator, special, pc, pcPlus4, instrValid, paused, halted,
           cycleCount, jumpCount, branchCount
  );

  modport slave (
    output go, instruction, pcWrite, jump, bltz, syscall, aluEqual, aluLess, rsValue, v0Value,
    input  instrAddr, operator, special, pc, pcPlus4, instrValid, paused, halted,
           cycleCount, jumpCount, branchCount
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register, ROM fetch/field split, next-PC select and the RUN/PAUSE/HALT syscall state machine.
// Statistics counters are built only when FETCH_STATS_EN is defined; otherwise they read zero.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [1:0] {RUN, PAUSE, HALT} state_e;

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_e      state_q;
  logic [31:0] pc_q, pc_d;
  logic        go_prev_q;
  logic        instr_valid_q, paused_q, halted_q;

  logic [31:0] pc_plus4, br_tgt, j_tgt, jr_tgt, next_pc;
  logic        is_jr, br_taken, go_edge, is_exit;
  logic        unused_ok;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{bus.instruction[15]}}, bus.instruction[15:0], 2'b00};
  assign j_tgt    = {pc_plus4[31:28], bus.instruction[25:0], 2'b00};
  assign jr_tgt   = {bus.rsValue[31:2], 2'b00};
  assign unused_ok = ^bus.rsValue[1:0];

  // jr and j/jal outrank every conditional branch, so a branch only counts as taken below them.
  assign is_jr    = (bus.pcWrite == 2'b01);
  assign br_taken = !is_jr && !bus.jump &&
                    (((bus.pcWrite == 2'b10) &&  bus.aluEqual) ||
                     ((bus.pcWrite == 2'b11) && !bus.aluEqual) ||
                     (bus.bltz && bus.aluLess));

  assign next_pc = is_jr    ? jr_tgt :
                   bus.jump ? j_tgt  :
                   br_taken ? br_tgt : pc_plus4;

  assign go_edge = bus.go && !go_prev_q;
  assign is_exit = (bus.v0Value == 32'd10);

  always_comb begin
    pc_d = pc_q;
    if (state_q == RUN) begin
      if (!bus.syscall)  pc_d = next_pc;
      else if (!is_exit) pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC_W;
      go_prev_q     <= 1'b0;
      instr_valid_q <= 1'b1;
      paused_q      <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      go_prev_q <= bus.go;
      pc_q      <= pc_d;
      case (state_q)
        RUN: begin
          if (bus.syscall) begin
            instr_valid_q <= 1'b0;
            if (is_exit) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q  <= PAUSE;
              paused_q <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (go_edge) begin
            state_q       <= RUN;
            paused_q      <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q       <= RUN;
          instr_valid_q <= 1'b1;
          paused_q      <= 1'b0;
          halted_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instrAddr  = pc_q[ROM_AW+1:2];
  assign bus.operator   = bus.instruction[31:26];
  assign bus.special    = bus.instruction[5:0];
  assign bus.pc         = pc_q;
  assign bus.pcPlus4    = pc_plus4;
  assign bus.instrValid = instr_valid_q;
  assign bus.paused     = paused_q;
  assign bus.halted     = halted_q;

`ifdef FETCH_STATS_EN
  logic [31:0] cycle_cnt_q, jump_cnt_q, branch_cnt_q;

  // The syscall cycle itself is still a RUN cycle and is counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q  <= 32'd0;
      jump_cnt_q   <= 32'd0;
      branch_cnt_q <= 32'd0;
    end else if (state_q == RUN) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (bus.jump || is_jr) jump_cnt_q   <= jump_cnt_q + 32'd1;
      if (br_taken)          branch_cnt_q <= branch_cnt_q + 32'd1;
    end
  end

  assign bus.cycleCount  = cycle_cnt_q;
  assign bus.jumpCount   = jump_cnt_q;
  assign bus.branchCount = branch_cnt_q;
`else
  assign bus.cycleCount  = 32'h0;
  assign bus.jumpCount   = 32'h0;
  assign bus.branchCount = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, hand-written syscall/go/halt/reset sequences,
// then random control traffic compared against a behavioural model.
module tb_fetch_pc_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.ROM_AW(10)) bus ();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .ROM_AW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef FETCH_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  pcw;
    logic        jmp, blz, eq, lt;
    logic [31:0] rs;
    logic [31:0] pc_before, pc_after;
    int          j_inc, b_inc;
  } vec_t;

  vec_t vt[17];

  logic [31:0] exp_c, exp_j, exp_b;

  task automatic drive_idle();
    bus.instruction = 32'h2108_0001;
    bus.pcWrite     = 2'b00;
    bus.jump        = 1'b0;
    bus.bltz        = 1'b0;
    bus.syscall     = 1'b0;
    bus.aluEqual    = 1'b0;
    bus.aluLess     = 1'b0;
    bus.rsValue     = 32'h0;
    bus.v0Value     = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string nm);
    chk({nm, ".cyc"}, bus.cycleCount,  stat(exp_c));
    chk({nm, ".jmp"}, bus.jumpCount,   stat(exp_j));
    chk({nm, ".br"},  bus.branchCount, stat(exp_b));
  endtask

  task automatic chk_state(input string nm, input logic [31:0] pc, input logic p, input logic h);
    chk({nm, ".pc"},     bus.pc,         pc);
    chk({nm, ".paused"}, {31'b0, bus.paused},     {31'b0, p});
    chk({nm, ".halted"}, {31'b0, bus.halted},     {31'b0, h});
    chk({nm, ".valid"},  {31'b0, bus.instrValid}, {31'b0, !(p || h)});
  endtask

  // Behavioural reference: architectural state updated once per rising edge from the spec rules.
  logic [31:0] m_pc, m_cyc, m_jmp, m_brc;
  logic        m_paused, m_halted, m_goprev;

  task automatic model_reset();
    m_pc = 32'h0; m_cyc = 0; m_jmp = 0; m_brc = 0;
    m_paused = 0; m_halted = 0; m_goprev = 0;
  endtask

  task automatic model_edge();
    logic [31:0] p4, tgt;
    int          imm;
    bit          taken;
    p4 = m_pc + 32'd4;
    if (!m_halted && m_paused) begin
      if (bus.go && !m_goprev) m_paused = 0;
    end else if (!m_halted) begin
      m_cyc = m_cyc + 1;
      if (bus.jump || bus.pcWrite == 2'd1) m_jmp = m_jmp + 1;
      taken = 0;
      imm   = int'($signed(bus.instruction[15:0]));
      if (bus.pcWrite == 2'd1)      tgt = bus.rsValue & 32'hFFFF_FFFC;
      else if (bus.jump)            tgt = (p4 & 32'hF000_0000) | ((bus.instruction & 32'h03FF_FFFF) << 2);
      else if ((bus.pcWrite == 2'd2 && bus.aluEqual) || (bus.pcWrite == 2'd3 && !bus.aluEqual) ||
               (bus.bltz && bus.aluLess)) begin
        taken = 1;
        tgt   = p4 + 32'(imm * 4);
      end else                      tgt = p4;
      if (taken) m_brc = m_brc + 1;
      if (bus.syscall) begin
        if (bus.v0Value == 32'd10) m_halted = 1;
        else begin m_paused = 1; m_pc = p4; end
      end else m_pc = tgt;
    end
    m_goprev = bus.go;
  endtask

  task automatic model_compare();
    chk("rnd.pc",      bus.pc,      m_pc);
    chk("rnd.pc4",     bus.pcPlus4, m_pc + 32'd4);
    chk("rnd.addr",    {22'b0, bus.instrAddr}, {22'b0, m_pc[11:2]});
    chk("rnd.op",      {26'b0, bus.operator}, {26'b0, bus.instruction[31:26]});
    chk("rnd.paused",  {31'b0, bus.paused},     {31'b0, m_paused});
    chk("rnd.halted",  {31'b0, bus.halted},     {31'b0, m_halted});
    chk("rnd.valid",   {31'b0, bus.instrValid}, {31'b0, !(m_paused || m_halted)});
    chk("rnd.cyc",     bus.cycleCount,  stat(m_cyc));
    chk("rnd.jmp",     bus.jumpCount,   stat(m_jmp));
    chk("rnd.br",      bus.branchCount, stat(m_brc));
  endtask

  initial begin
    // instr, pcWrite, jump, bltz, eq, less, rs, pc before, pc after, jump inc, branch inc
    vt[0]  = '{32'h2108_0001, 2'd0, 0, 0, 0, 0, 32'h0,   32'h00,  32'h04,  0, 0};
    vt[1]  = '{32'h2108_0001, 2'd0, 0, 0, 0, 0, 32'h0,   32'h04,  32'h08,  0, 0};
    vt[2]  = '{32'h2108_0001, 2'd0, 0, 0, 0, 0, 32'h0,   32'h08,  32'h0C,  0, 0};
    vt[3]  = '{32'h2108_0001, 2'd0, 0, 0, 0, 0, 32'h0,   32'h0C,  32'h10,  0, 0};
    vt[4]  = '{32'h1022_FFFE, 2'd2, 0, 0, 1, 0, 32'h0,   32'h10,  32'h0C,  0, 1};
    vt[5]  = '{32'h2108_0001, 2'd0, 0, 0, 0, 0, 32'h0,   32'h0C,  32'h10,  0, 0};
    vt[6]  = '{32'h1022_FFFE, 2'd2, 0, 0, 0, 0, 32'h0,   32'h10,  32'h14,  0, 0};
    vt[7]  = '{32'h03E0_0008, 2'd1, 0, 0, 0, 0, 32'h103, 32'h14,  32'h100, 1, 0};
    vt[8]  = '{32'h0800_0008, 2'd0, 1, 0, 0, 0, 32'h0,   32'h100, 32'h20,  1, 0};
    vt[9]  = '{32'h0C00_0040, 2'd0, 1, 0, 0, 0, 32'h0,   32'h20,  32'h100, 1, 0};
    vt[10] = '{32'h1422_0003, 2'd3, 0, 0, 1, 0, 32'h0,   32'h100, 32'h104, 0, 0};
    vt[11] = '{32'h0420_FFBF, 2'd0, 0, 1, 0, 1, 32'h0,   32'h104, 32'h04,  0, 1};
    vt[12] = '{32'h0420_FFBF, 2'd0, 0, 1, 0, 0, 32'h0,   32'h04,  32'h08,  0, 0};
    vt[13] = '{32'h03E0_0008, 2'd1, 1, 1, 0, 1, 32'h31,  32'h08,  32'h30,  1, 0};
    vt[14] = '{32'h0800_000C, 2'd2, 1, 0, 1, 0, 32'h0,   32'h30,  32'h30,  1, 0};
    vt[15] = '{32'h1422_0003, 2'd3, 0, 0, 0, 0, 32'h0,   32'h30,  32'h40,  0, 1};
    vt[16] = '{32'h1022_FFFB, 2'd2, 0, 0, 1, 0, 32'h0,   32'h40,  32'h30,  0, 1};

    rst_n  = 1'b0;
    bus.go = 1'b0;
    drive_idle();
    exp_c = 0; exp_j = 0; exp_b = 0;
    repeat (2) tick();
    chk_state("reset", 32'h0, 0, 0);
    chk_stats("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      bus.instruction = vt[i].instr;
      bus.pcWrite     = vt[i].pcw;
      bus.jump        = vt[i].jmp;
      bus.bltz        = vt[i].blz;
      bus.aluEqual    = vt[i].eq;
      bus.aluLess     = vt[i].lt;
      bus.rsValue     = vt[i].rs;
      @(negedge clk);
      chk($sformatf("vec%0d.pc", i),   bus.pc,      vt[i].pc_before);
      chk($sformatf("vec%0d.pc4", i),  bus.pcPlus4, vt[i].pc_before + 32'd4);
      chk($sformatf("vec%0d.addr", i), {22'b0, bus.instrAddr}, {22'b0, vt[i].pc_before[11:2]});
      chk($sformatf("vec%0d.op", i),   {26'b0, bus.operator},  {26'b0, vt[i].instr[31:26]});
      chk($sformatf("vec%0d.fn", i),   {26'b0, bus.special},   {26'b0, vt[i].instr[5:0]});
      chk($sformatf("vec%0d.valid", i), {31'b0, bus.instrValid}, 32'd1);
      tick();
      chk($sformatf("vec%0d.next", i), bus.pc, vt[i].pc_after);
      exp_c = exp_c + 1;
      exp_j = exp_j + 32'(vt[i].j_inc);
      exp_b = exp_b + 32'(vt[i].b_inc);
      if (i == 3) chk("straight.cyc", bus.cycleCount, stat(32'd4));
    end
    chk_stats("table");

    // syscall with a non-exit service code pauses after PC+4
    drive_idle();
    bus.instruction = 32'h0000_000C; bus.syscall = 1; bus.v0Value = 32'd34;
    tick();
    exp_c = exp_c + 1;
    chk_state("pause", 32'h34, 1, 0);
    drive_idle();
    bus.jump = 1; bus.pcWrite = 2'd1; bus.rsValue = 32'h200;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_state("pause.hold", 32'h34, 1, 0);
      chk_stats("pause.hold");
    end
    drive_idle();
    bus.go = 1; tick();
    chk_state("resume", 32'h34, 0, 0);
    tick();
    exp_c = exp_c + 1;
    chk_state("resume.exec", 32'h38, 0, 0);
    chk_stats("resume.exec");

    // go still held from the earlier press: a fresh pause must not be released by it
    bus.instruction = 32'h0000_000C; bus.syscall = 1; bus.v0Value = 32'd34;
    tick();
    exp_c = exp_c + 1;
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_state("go.held", 32'h3C, 1, 0);
    end
    bus.go = 0; tick();
    chk_state("go.low", 32'h3C, 1, 0);
    bus.go = 1; tick();
    chk_state("go.repress", 32'h3C, 0, 0);
    bus.go = 0;

    // exit syscall halts with PC unchanged; go pulses are ignored
    bus.instruction = 32'h0000_000C; bus.syscall = 1; bus.v0Value = 32'd10;
    tick();
    exp_c = exp_c + 1;
    chk_state("halt", 32'h3C, 0, 1);
    drive_idle();
    for (int k = 0; k < 6; k++) begin
      bus.go = (k % 2 == 0);
      tick();
      chk_state("halt.go", 32'h3C, 0, 1);
    end
    chk_stats("halt");

    // asynchronous reset in the middle of a cycle
    #2 rst_n = 0;
    #1;
    exp_c = 0; exp_j = 0; exp_b = 0;
    chk_state("arst", 32'h0, 0, 0);
    chk_stats("arst");
    bus.go = 1'b0;
    tick();
    rst_n = 1;

    // random traffic against the model
    model_reset();
    begin
      int halt_cycles;
      halt_cycles = 0;
      for (int n = 0; n < 1500; n++) begin
        bus.instruction = $urandom;
        bus.rsValue     = $urandom;
        bus.pcWrite     = 2'($urandom_range(0, 3));
        bus.jump        = ($urandom_range(0, 5) == 0);
        bus.bltz        = ($urandom_range(0, 3) == 0);
        bus.aluEqual    = 1'($urandom_range(0, 1));
        bus.aluLess     = 1'($urandom_range(0, 1));
        bus.syscall     = ($urandom_range(0, 11) == 0);
        bus.v0Value     = ($urandom_range(0, 5) == 0) ? 32'd10 : 32'($urandom_range(0, 40));
        if (bus.syscall) begin
          bus.pcWrite = 2'd0; bus.jump = 0; bus.bltz = 0;
        end
        if ($urandom_range(0, 2) == 0) bus.go = ~bus.go;
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_edge();
        #1;
        if (m_halted) halt_cycles++;
        if (halt_cycles > 4) begin
          #2 rst_n = 0;
          #1;
          model_reset();
          chk("rnd.arst.pc", bus.pc, m_pc);
          chk("rnd.arst.halted", {31'b0, bus.halted}, 32'd0);
          @(posedge clk);
          #1 rst_n = 1;
          m_goprev = 0;
          halt_cycles = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
